// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase sequencer.
//   state_t      : controller state (IDLE, RUN, DONE)
//   phase_idx_w  : width of a phase index for a given phase count (min 1)
package phase_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int phase_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_sequencer_period_timer.sv
// Free-running counter with a runtime modulus.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear to 0 (has priority over enable)
//   enable     : count when high
//   period     : modulus P; counts 0..P-1, a period of 0 behaves as 1
//   tick       : high while enabled and on the last count of the period
module period_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] last;

  // Period 0 collapses onto period 1: the last count is then 0.
  assign last = (period == '0) ? '0 : period - W'(1);
  assign tick = enable && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Programmable multi-phase timing controller.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : begin a run (sampled only in IDLE; stop wins if both high)
//   stop        : synchronous abort, sampled in any state
//   period_in   : packed period table, phase p at [p*W +: W] (snapshotted on start)
//   repeat_in   : number of rounds, 0 = run until stop (snapshotted on start)
//   busy        : high in RUN
//   phase_idx   : current phase
//   phase_tick  : last cycle of each phase
//   round_tick  : last cycle of the final phase of a round
//   done        : one-cycle pulse after the final round
//   rounds_done : completed rounds of the current or last run
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int W        = 8,
  parameter int N_PHASES = 4,
  parameter int RW       = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              stop,
  input  logic [N_PHASES*W-1:0]             period_in,
  input  logic [RW-1:0]                     repeat_in,
  output logic                              busy,
  output logic [phase_idx_w(N_PHASES)-1:0]  phase_idx,
  output logic                              phase_tick,
  output logic                              round_tick,
  output logic                              done,
  output logic [RW-1:0]                     rounds_done
);

  localparam int PIW = phase_idx_w(N_PHASES);
  localparam logic [PIW-1:0] LAST_PHASE = PIW'(N_PHASES - 1);
  localparam logic [RW-1:0]  RND_MAX    = '1;

  state_t                state_q, state_d;
  logic [N_PHASES*W-1:0] per_q, per_d;
  logic [RW-1:0]         rep_q, rep_d;
  logic [PIW-1:0]        phase_q, phase_d;
  logic [RW-1:0]         rounds_q, rounds_d;
  logic [RW-1:0]         rounds_inc;
  logic [W-1:0]          cur_period;
  logic                  tmr_tick;
  logic                  in_run;

  assign in_run     = (state_q == ST_RUN);
  assign cur_period = per_q[int'(phase_q)*W +: W];

  // Timer is held at 0 outside RUN, so every run starts phase 0 from count 0.
  period_timer #(.W(W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_run),
    .enable (in_run),
    .period (cur_period),
    .tick   (tmr_tick)
  );

  // Round count saturates; with a nonzero repeat it never reaches the ceiling.
  assign rounds_inc = (rounds_q == RND_MAX) ? rounds_q : rounds_q + RW'(1);

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    rep_d    = rep_q;
    phase_d  = phase_q;
    rounds_d = rounds_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d  = ST_RUN;
          per_d    = period_in;
          rep_d    = repeat_in;
          phase_d  = '0;
          rounds_d = '0;
        end
      end
      ST_RUN: begin
        // Abort takes priority over any tick in the same cycle.
        if (stop) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (tmr_tick) begin
          if (phase_q == LAST_PHASE) begin
            phase_d  = '0;
            rounds_d = rounds_inc;
            if ((rep_q != '0) && (rounds_inc == rep_q)) begin
              state_d = ST_DONE;
            end
          end else begin
            phase_d = phase_q + PIW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      per_q    <= '0;
      rep_q    <= '0;
      phase_q  <= '0;
      rounds_q <= '0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      rep_q    <= rep_d;
      phase_q  <= phase_d;
      rounds_q <= rounds_d;
    end
  end

  assign busy        = in_run;
  assign done        = (state_q == ST_DONE);
  assign phase_idx   = phase_q;
  assign phase_tick  = tmr_tick;
  assign round_tick  = tmr_tick && (phase_q == LAST_PHASE);
  assign rounds_done = rounds_q;

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Programmable multi-phase timing controller built around a runtime-modulus tick counter. On a start request it snapshots a per-phase period table and a repeat count, then steps through N_PHASES phases. Each phase lasts exactly its programmed number of clk cycles. It emits per-phase ticks and a completion pulse. It sequences downstream datapaths such as display multiplexing, PWM frames and light-controller timing.

Parameters:
W, 8, width of each phase period value and of the internal timer
N_PHASES, 4, number of phases per round (>=2)
RW, 8, width of repeat count and round counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a run; sampled only in IDLE
stop  input  1  synchronous abort; sampled in any state
period_in  input  N_PHASES*W  packed period table; phase p occupies bits [p*W +: W]
repeat_in  input  RW  number of rounds; 0 = run until stop
busy  output  1  high while in RUN
phase_idx  output  $clog2(N_PHASES)  current phase index
phase_tick  output  1  high during the last cycle of every phase
round_tick  output  1  high during the last cycle of phase N_PHASES-1
done  output  1  one-cycle pulse when the final round completes
rounds_done  output  RW  completed rounds in the current or last run

Behaviour:
- Reset (async): state=IDLE, all outputs 0, timer 0, period snapshot 0.
- States: IDLE, RUN, DONE.
  - IDLE->RUN: on start=1 and stop=0.
  - RUN->IDLE: on stop=1.
  - RUN->DONE: on the final round_tick.
  - DONE->IDLE: unconditional after 1 cycle.
- Start (IDLE, start=1, stop=0) at edge k: latch period_in and repeat_in; phase_idx=0, timer=0, rounds_done=0. Cycle after edge k is the first cycle of phase 0, with busy=1.
- Simultaneous start and stop in IDLE: stop wins; remain IDLE.
- Inputs period_in and repeat_in are ignored after the snapshot; changing them mid-run has no effect.
- Timer in RUN:
  - Counts 0..P-1, where P is the snapshotted period of the current phase.
  - Period 0 is treated as 1.
  - phase_tick = (timer == P-1) && RUN.
  - On a phase_tick cycle: timer -> 0 and phase_idx -> phase_idx+1, wrapping N_PHASES-1 -> 0.
  - Phase p lasts exactly max(P_p,1) cycles.
- Round end:
  - round_tick = phase_tick && phase_idx == N_PHASES-1.
  - On round_tick, rounds_done increments; it saturates at 2^RW-1 when repeat is 0.
  - If repeat != 0 and rounds_done+1 == repeat, go to DONE; otherwise continue with phase 0.
- DONE: busy=0, done=1 for exactly one cycle. phase_idx resets to 0; rounds_done holds its final value until the next start.
- Stop in RUN: next cycle is IDLE, busy=0, done never asserted, rounds_done holds its partial value, phase_idx -> 0.
- start while busy or in DONE is ignored; no queuing.
- Reset mid-run: immediate return to reset values; no done pulse.
- All outputs are derived from registers plus state compare. No combinational path from inputs to outputs.

Decomposition:
- Package phase_seq_pkg: state enum type (IDLE, RUN, DONE); helper constant for phase index width.
- Sub-module period_timer (clk, reset, clear, enable, period[W], tick): free counter with runtime modulus, sync clear, tick on last count. The top-level FSM drives clear/enable and indexes the period snapshot.

Test Plan:
1. Basic run: periods {3,1,2,4}, repeat=1, start at cycle 0.
   - busy high cycles 1-10.
   - phase_idx 0,0,0,1,2,2,3,3,3,3.
   - phase_tick at cycles 3,4,6,10; round_tick at 10.
   - done at 11; rounds_done=1.
2. Repeat and zero period: periods {0,2,1,1}, repeat=3.
   - Phase 0 lasts 1 cycle; each round is 5 cycles.
   - Three round_ticks, 5 cycles apart; done 1 cycle after the third; rounds_done=3.
3. Infinite run then stop: repeat=0, periods {2,2,2,2}, run 20 cycles, then assert stop.
   - round_tick every 8 cycles.
   - busy=0 next cycle, no done, rounds_done=2.
4. Snapshot and ignore: change period_in to all 9s mid-run and pulse start while busy.
   - Timing is unchanged from the original snapshot; no restart.
5. Start and stop together in IDLE: busy stays 0.
6. Async reset asserted mid-phase 2: all outputs 0 immediately. A later start runs cleanly from phase 0.
